// File: rtl/seq_divider.sv
// Sequential 32-bit restoring divider (DIV/DIVU) producing HI/LO results in 34 cycles.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips CALC/FIX and completes the cycle after start.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] quo, dvs;
  logic             sign_dd, sign_dv, sgn_mode, dvs_zero;
  logic             busy_nxt, done_nxt;
  logic             fast_zero;
  logic [WIDTH-1:0] dd_mag, dv_mag, q_fix, r_fix;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;
  logic             unused_part_msb;

`ifdef DIV_ZERO_FAST_EN
  always_comb fast_zero = (divisor == '0);
`else
  always_comb fast_zero = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = fast_zero ? DONE : CALC;
      CALC:    if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs, decoded from the next state so they register in step with it
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == CALC || state_nxt == FIX) busy_nxt = 1'b1;
    if (state_nxt == DONE)                     done_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Operand magnitudes, one restoring step, and sign fix-up
  always_comb begin
    dd_mag  = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dv_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    shifted = {part[WIDTH-1:0], quo[WIDTH-1]};
    fits    = (shifted >= {1'b0, dvs});
    diff    = shifted - {1'b0, dvs};
    q_fix   = (sgn_mode && (sign_dd ^ sign_dv)) ? -quo : quo;
    r_fix   = (sgn_mode && sign_dd) ? -part[WIDTH-1:0] : part[WIDTH-1:0];
    unused_part_msb = part[WIDTH];
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      part        <= '0;
      quo         <= '0;
      dvs         <= '0;
      sign_dd     <= 1'b0;
      sign_dv     <= 1'b0;
      sgn_mode    <= 1'b0;
      dvs_zero    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          count    <= CW'(WIDTH - 1);
          part     <= '0;
          quo      <= dd_mag;
          dvs      <= dv_mag;
          sign_dd  <= is_signed & dividend[WIDTH-1];
          sign_dv  <= is_signed & divisor[WIDTH-1];
          sgn_mode <= is_signed;
          dvs_zero <= (divisor == '0);
          if (fast_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end
        end
        CALC: begin
          part <= fits ? diff : shifted;
          quo  <= {quo[WIDTH-2:0], fits};
          if (count != '0) count <= count - CW'(1);
        end
        // Divide-by-zero leaves the magnitude remainder equal to |dividend|, so the
        // remainder sign fix-up restores the raw dividend; only the quotient is forced.
        FIX: begin
          quotient    <= dvs_zero ? '1 : q_fix;
          remainder   <= r_fix;
          div_by_zero <= dvs_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against an arithmetic reference model.
// Honours DIV_ZERO_FAST_EN when the same macro is defined for the bench.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero
  task automatic ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    longint unsigned ua, ub;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else if (sg) begin
      sa = longint'($signed(a)); sb = longint'($signed(b));
      q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0;
    end else begin
      ua = {32'd0, a}; ub = {32'd0, b};
      q = 32'(ua / ub); r = 32'(ua % ub); z = 1'b0;
    end
  endtask

  task automatic do_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input bit glitch);
    logic [31:0] eq, er;
    logic ez;
    int lat, bcnt, exp_lat;
    ref_div(sg, a, b, eq, er, ez);
    exp_lat = 33;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) exp_lat = 0;
`endif
    @(negedge clk);
    start = 1'b1; is_signed = sg; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; is_signed = 1'($urandom); dividend = $urandom; divisor = $urandom;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      bcnt += int'(busy);
      @(negedge clk);
      lat++;
      if (glitch && lat == 5) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    check("latency", lat, exp_lat);
    check("busy_cycles", bcnt, exp_lat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, ez);
    // A start presented during DONE must be dropped
    start = 1'b1; dividend = $urandom; divisor = $urandom;
    @(negedge clk);
    start = 1'b0;
    check("done_single_pulse", done, 0);
    check("start_in_done_ignored", busy, 0);
    check("hold_quotient", quotient, eq);
    check("hold_remainder", remainder, er);
  endtask

  initial begin
    logic [31:0] a, b;
    int sel;
    bit seen;
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;

    do_op(1'b0, 32'd100, 32'd7, 1'b0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op(1'b1, 32'h1234_5678, 32'd0, 1'b0);
    do_op(1'b0, 32'h8765_4321, 32'd0, 1'b1);

    // Abort mid-operation with reset; a stray start in CALC must not queue
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      start = (k == 4);
      if (k == 9)  rst = 1'b1;
      if (k == 11) rst = 1'b0;
    end
    check("abort_no_done", 32'(seen), 0);
    check("abort_busy", busy, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    do_op(1'b0, 32'd50, 32'd5, 1'b0);

    // Reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_priority_busy", busy, 0);
    @(negedge clk);
    check("rst_priority_no_queue", busy, 0);
    check("rst_priority_done", done, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 5);
      case (sel)
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: a = $urandom_range(0, 1000);
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      do_op(1'($urandom), a, b, (i % 2) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
